// File: rtl/banco_pkg.sv
// Shared defaults, register-file types and the population-count helper
// used by the register bank and its pending-writeback tracker.
package banco_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Widest pending vector popcount() accepts; callers zero-extend into it.
  localparam int POP_MAX = 1024;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  // Number of set bits in v.
  function automatic logic [31:0] popcount(input logic [POP_MAX-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int k = 0; k < POP_MAX; k++) begin
      n = n + {31'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/banco_registros_mp_if.sv
// Read, writeback, issue and status signals of the multi-port register bank.
interface banco_registros_mp_if
  import banco_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [NRD-1:0][AW-1:0]   readReg;
  logic [NRD-1:0][XLEN-1:0] readData;
  logic [NRD-1:0]           readBusy;
  logic [AW-1:0]            writeReg;
  logic [XLEN-1:0]          writeData;
  logic                     RegWrite;
  logic [AW-1:0]            issueReg;
  logic                     issueValid;
  logic [CW-1:0]            pendCount;
  logic                     wbErr;

  // Pipeline side: presents addresses, writebacks and issues.
  modport master (
    output readReg, writeReg, writeData, RegWrite, issueReg, issueValid,
    input  readData, readBusy, pendCount, wbErr
  );

  // Register bank side.
  modport slave (
    input  readReg, writeReg, writeData, RegWrite, issueReg, issueValid,
    output readData, readBusy, pendCount, wbErr
  );
endinterface

// File: rtl/marcador_pendientes.sv
// Pending-writeback scoreboard: one bit per register, registered count of
// pending registers, and a sticky flag for writebacks nobody was waiting on.
module marcador_pendientes
  import banco_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(NREGS + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [AW-1:0]    writeReg,
  input  logic             RegWrite,
  input  logic [AW-1:0]    issueReg,
  input  logic             issueValid,
  output logic [NREGS-1:0] pending,
  output logic [CW-1:0]    pendCount,
  output logic             wbErr
);

  logic [NREGS-1:0]   pendingReg, pendingNext;
  logic [CW-1:0]      pendCountReg, pendCountNext;
  logic               wbErrReg, wbErrNext;
  logic [POP_MAX-1:0] popVec;
  logic [31:0]        popRaw;

  // x0 is never pending; for the rest a same-edge issue beats the writeback
  // so a back-to-back producer keeps its consumers stalled.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
    if (gi == 0) begin : g_zero
      assign pendingNext[gi] = 1'b0;
    end else begin : g_bit
      assign pendingNext[gi] = (issueValid && issueReg == AW'(gi)) ||
                               (pendingReg[gi] && !(RegWrite && writeReg == AW'(gi)));
    end
  end

  // Next count and error flag; count follows the bits as they will be after the edge.
  always_comb begin
    popVec                = '0;
    popVec[NREGS-1:0]     = pendingNext;
    popRaw                = popcount(popVec);
    if (popRaw > 32'(NREGS - 1)) begin
      pendCountNext = CW'(NREGS - 1);
    end else begin
      pendCountNext = popRaw[CW-1:0];
    end
    wbErrNext = wbErrReg | (RegWrite && writeReg != '0 && !pendingReg[writeReg]);
  end

  // Scoreboard state, cleared the moment reset asserts.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pendingReg   <= '0;
      pendCountReg <= '0;
      wbErrReg     <= 1'b0;
    end else begin
      pendingReg   <= pendingNext;
      pendCountReg <= pendCountNext;
      wbErrReg     <= wbErrNext;
    end
  end

  assign pending   = pendingReg;
  assign pendCount = pendCountReg;
  assign wbErr     = wbErrReg;

endmodule

// File: rtl/banco_registros_mp.sv
// Multi-read-port register file with x0 hardwired to zero, optional
// write-first forwarding, and a pending-writeback scoreboard.
module banco_registros_mp
  import banco_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic                 CLK,
  input logic                 RESET_N,
  banco_registros_mp_if.slave bus
);

  // Storage clears asynchronously, so it lives in flops rather than block RAM.
  logic [XLEN-1:0]  regFile [NREGS];
  logic [NREGS-1:0] pending;

  // Register writes; x0 is never written so it always holds zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < NREGS; k++) begin
        regFile[k] <= '0;
      end
    end else if (bus.RegWrite && bus.writeReg != '0) begin
      regFile[bus.writeReg] <= bus.writeData;
    end
  end

  // Read ports: forwarding is gated by reset so every output is zero in reset.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic hit;
    assign hit = (BYPASS != 0) && RESET_N && bus.RegWrite &&
                 bus.readReg[gi] != '0 && bus.writeReg == bus.readReg[gi];
    assign bus.readData[gi] = (!RESET_N || bus.readReg[gi] == '0) ? '0 :
                              hit ? bus.writeData : regFile[bus.readReg[gi]];
    assign bus.readBusy[gi] = pending[bus.readReg[gi]] && !hit;
  end

  marcador_pendientes #(
    .NREGS (NREGS)
  ) u_marcador (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .writeReg   (bus.writeReg),
    .RegWrite   (bus.RegWrite),
    .issueReg   (bus.issueReg),
    .issueValid (bus.issueValid),
    .pending    (pending),
    .pendCount  (bus.pendCount),
    .wbErr      (bus.wbErr)
  );

endmodule

// File: tb/tb_banco_registros_mp.sv
// Directed bench: one forwarding and one read-old instance share stimulus.
module tb_banco_registros_mp;
  import banco_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  banco_registros_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifa ();
  banco_registros_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifb ();

  banco_registros_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dutA (
    .CLK(CLK), .RESET_N(RESET_N), .bus(ifa.slave));
  banco_registros_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dutB (
    .CLK(CLK), .RESET_N(RESET_N), .bus(ifb.slave));

  typedef struct {
    logic [4:0]  wr;  logic [31:0] wd; logic we;
    logic [4:0]  ir;  logic iv;
    logic [4:0]  r0;  logic [4:0] r1;
    logic [31:0] e0;  logic [31:0] e1;
    logic        eb0; logic eb1;
    logic [5:0]  epc; logic eerr;
    logic [31:0] e1b; logic eb1b;   // read-old instance, port 1
  } vec_t;

  vec_t tbl [19];
  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic setIn(input logic [4:0] wr, input logic [31:0] wd, input logic we,
                       input logic [4:0] ir, input logic iv,
                       input logic [4:0] r0, input logic [4:0] r1);
    ifa.writeReg = wr; ifa.writeData = wd; ifa.RegWrite = we;
    ifa.issueReg = ir; ifa.issueValid = iv;
    ifa.readReg[0] = r0; ifa.readReg[1] = r1;
    ifb.writeReg = wr; ifb.writeData = wd; ifb.RegWrite = we;
    ifb.issueReg = ir; ifb.issueValid = iv;
    ifb.readReg[0] = r0; ifb.readReg[1] = r1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " dataA0"}, ifa.readData[0], 32'h0);
    check({tag, " dataA1"}, ifa.readData[1], 32'h0);
    check({tag, " dataB1"}, ifb.readData[1], 32'h0);
    check({tag, " busyA"},  32'(ifa.readBusy), 32'h0);
    check({tag, " busyB"},  32'(ifb.readBusy), 32'h0);
    check({tag, " pcA"},    32'(ifa.pendCount), 32'h0);
    check({tag, " errA"},   32'(ifa.wbErr), 32'h0);
    check({tag, " errB"},   32'(ifb.wbErr), 32'h0);
  endtask

  initial begin
    //          wr     wd             we    ir     iv    r0     r1     e0             e1             eb0   eb1   epc   eerr  e1b            eb1b
    tbl[0]  = '{5'd0,  32'h0000_00A1, 1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 6'd0, 1'b0, 32'h0,         1'b0};
    tbl[1]  = '{5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 6'd0, 1'b0, 32'h0,         1'b0};
    tbl[2]  = '{5'd0,  32'h0,         1'b0, 5'd13, 1'b1, 5'd13, 5'd13, 32'h0,         32'h0,         1'b0, 1'b0, 6'd0, 1'b0, 32'h0,         1'b0};
    tbl[3]  = '{5'd0,  32'h0,         1'b0, 5'd16, 1'b1, 5'd13, 5'd16, 32'h0,         32'h0,         1'b1, 1'b0, 6'd1, 1'b0, 32'h0,         1'b0};
    tbl[4]  = '{5'd13, 32'h0000_A234, 1'b1, 5'd24, 1'b1, 5'd13, 5'd16, 32'h0000_A234, 32'h0,         1'b0, 1'b1, 6'd2, 1'b0, 32'h0,         1'b1};
    tbl[5]  = '{5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd13, 5'd24, 32'h0000_A234, 32'h0,         1'b0, 1'b1, 6'd2, 1'b0, 32'h0,         1'b1};
    tbl[6]  = '{5'd16, 32'h0000_1234, 1'b1, 5'd0,  1'b0, 5'd16, 5'd24, 32'h0000_1234, 32'h0,         1'b0, 1'b1, 6'd2, 1'b0, 32'h0,         1'b1};
    tbl[7]  = '{5'd24, 32'h0000_2345, 1'b1, 5'd0,  1'b0, 5'd16, 5'd24, 32'h0000_1234, 32'h0000_2345, 1'b0, 1'b0, 6'd1, 1'b0, 32'h0,         1'b1};
    tbl[8]  = '{5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd16, 5'd24, 32'h0000_1234, 32'h0000_2345, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0000_2345, 1'b0};
    tbl[9]  = '{5'd0,  32'h0,         1'b0, 5'd5,  1'b1, 5'd5,  5'd5,  32'h0,         32'h0,         1'b0, 1'b0, 6'd0, 1'b0, 32'h0,         1'b0};
    tbl[10] = '{5'd5,  32'hDEAD_BEEF, 1'b1, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 6'd1, 1'b0, 32'h0,         1'b1};
    tbl[11] = '{5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 6'd0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{5'd0,  32'h0,         1'b0, 5'd7,  1'b1, 5'd7,  5'd7,  32'h0,         32'h0,         1'b0, 1'b0, 6'd0, 1'b0, 32'h0,         1'b0};
    tbl[13] = '{5'd7,  32'h0000_0077, 1'b1, 5'd7,  1'b1, 5'd7,  5'd7,  32'h0000_0077, 32'h0000_0077, 1'b0, 1'b0, 6'd1, 1'b0, 32'h0,         1'b1};
    tbl[14] = '{5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  32'h0000_0077, 32'h0000_0077, 1'b1, 1'b1, 6'd1, 1'b0, 32'h0000_0077, 1'b1};
    tbl[15] = '{5'd7,  32'h0000_0078, 1'b1, 5'd0,  1'b0, 5'd7,  5'd7,  32'h0000_0078, 32'h0000_0078, 1'b0, 1'b0, 6'd1, 1'b0, 32'h0000_0077, 1'b1};
    tbl[16] = '{5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  32'h0000_0078, 32'h0000_0078, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0000_0078, 1'b0};
    tbl[17] = '{5'd9,  32'h0000_0099, 1'b1, 5'd0,  1'b0, 5'd9,  5'd9,  32'h0000_0099, 32'h0000_0099, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0,         1'b0};
    tbl[18] = '{5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'h0000_0099, 32'h0000_0099, 1'b0, 1'b0, 6'd0, 1'b1, 32'h0000_0099, 1'b0};

    // Reset state.
    RESET_N = 1'b0;
    setIn(5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkAllZero("reset");
    RESET_N = 1'b1;

    // Table: inputs change on the falling edge, outputs sampled 2 ns later.
    for (int i = 0; i < 19; i++) begin
      setIn(tbl[i].wr, tbl[i].wd, tbl[i].we, tbl[i].ir, tbl[i].iv, tbl[i].r0, tbl[i].r1);
      #2;
      $display("[TB] vec %0d: wr=%0d we=%0b ir=%0d iv=%0b rd=(%0d,%0d) -> data=(%h,%h) busy=%b pc=%0d err=%0b",
               i, tbl[i].wr, tbl[i].we, tbl[i].ir, tbl[i].iv, tbl[i].r0, tbl[i].r1,
               ifa.readData[0], ifa.readData[1], ifa.readBusy, ifa.pendCount, ifa.wbErr);
      check($sformatf("v%0d dataA0", i), ifa.readData[0], tbl[i].e0);
      check($sformatf("v%0d dataA1", i), ifa.readData[1], tbl[i].e1);
      check($sformatf("v%0d busyA0", i), 32'(ifa.readBusy[0]), 32'(tbl[i].eb0));
      check($sformatf("v%0d busyA1", i), 32'(ifa.readBusy[1]), 32'(tbl[i].eb1));
      check($sformatf("v%0d pcA", i),    32'(ifa.pendCount), 32'(tbl[i].epc));
      check($sformatf("v%0d errA", i),   32'(ifa.wbErr), 32'(tbl[i].eerr));
      check($sformatf("v%0d dataB1", i), ifb.readData[1], tbl[i].e1b);
      check($sformatf("v%0d busyB1", i), 32'(ifb.readBusy[1]), 32'(tbl[i].eb1b));
      @(negedge CLK);
    end

    // Reset asserted mid-cycle while a write and an issue to reg 9 are presented.
    setIn(5'd9, 32'hFFFF_FFFF, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9);
    #2;
    RESET_N = 1'b0;
    #1;
    $display("[TB] async reset mid-write: data=(%h,%h) pc=%0d err=%0b",
             ifa.readData[0], ifa.readData[1], ifa.pendCount, ifa.wbErr);
    checkAllZero("async");
    @(negedge CLK);
    #2;
    $display("[TB] held in reset across an edge with write/issue active");
    checkAllZero("held");

    // Release: reg 9 reads back zero, nothing pending.
    setIn(5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
    RESET_N = 1'b1;
    #2;
    $display("[TB] after release: reg9=%h", ifa.readData[0]);
    checkAllZero("release");
    @(negedge CLK);

    // First write after release lands on the first rising edge.
    setIn(5'd3, 32'h0000_0033, 1'b1, 5'd0, 1'b0, 5'd3, 5'd0);
    @(negedge CLK);
    setIn(5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
    #2;
    $display("[TB] first write after reset: reg3=%h err=%0b", ifb.readData[0], ifa.wbErr);
    check("first write A", ifa.readData[0], 32'h0000_0033);
    check("first write B", ifb.readData[0], 32'h0000_0033);
    check("first write err", 32'(ifa.wbErr), 32'h1);
    @(negedge CLK);

    // Every register except x0 pending: the count tops out at NREGS-1.
    for (int r = 1; r < 32; r++) begin
      setIn(5'd0, 32'h0, 1'b0, 5'(r), 1'b1, 5'd0, 5'd31);
      @(negedge CLK);
    end
    setIn(5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd31);
    #2;
    $display("[TB] all issued: pc=%0d busy0=%0b busy1=%0b", ifa.pendCount, ifa.readBusy[0], ifa.readBusy[1]);
    check("full pc", 32'(ifa.pendCount), 32'd31);
    check("full busy x0", 32'(ifa.readBusy[0]), 32'h0);
    check("full busy x31", 32'(ifa.readBusy[1]), 32'h1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/banco_registros_mp.md
BANCO_REGISTROS_MP -- requirements
Module: banco_registros_mp

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 The module SHALL have parameter NREGS, default 32, number of registers (power of two, >= 2).
REQ-003 The module SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 The module SHALL have parameter BYPASS, default 1, with 1 = write-first forwarding and 0 = read-old.
REQ-005 The module SHALL have port CLK, input, 1 bit, single clock; all state SHALL update on the rising edge.
REQ-006 The module SHALL have port RESET_N, input, 1 bit, reset, asynchronous and active-low.
REQ-007 The module SHALL have port readReg, input, NRD x AW bits, read addresses, where AW = clog2(NREGS).
REQ-008 The module SHALL have port readData, output, NRD x XLEN bits, read data.
REQ-009 The module SHALL have port readBusy, output, NRD bits, addressed register has an outstanding writeback.
REQ-010 The module SHALL have port writeReg, input, AW bits, writeback address.
REQ-011 The module SHALL have port writeData, input, XLEN bits, writeback data.
REQ-012 The module SHALL have port RegWrite, input, 1 bit, writeback enable.
REQ-013 The module SHALL have port issueReg, input, AW bits, destination of the newly issued instruction.
REQ-014 The module SHALL have port issueValid, input, 1 bit, marks issueReg pending.
REQ-015 The module SHALL have port pendCount, output, clog2(NREGS+1) bits, number of pending registers.
REQ-016 The module SHALL have port wbErr, output, 1 bit, sticky flag: writeback to a non-pending register.

Function
REQ-017 A register write SHALL occur on the CLK rising edge when RegWrite=1 and writeReg!=0; writes to x0 SHALL be discarded.
REQ-018 readData[i] SHALL be combinational from readReg[i]; address 0 SHALL always read 0.
REQ-019 When BYPASS=1, RegWrite=1 and writeReg==readReg[i]!=0, readData[i] SHALL equal writeData in the same cycle.
REQ-020 When BYPASS=0, readData[i] SHALL return the stored value until the edge after the write.
REQ-021 Each register SHALL have one pending bit; the bit SHALL be set on the edge where issueValid=1 and issueReg!=0.
REQ-022 The pending bit SHALL clear on the edge where RegWrite=1 and writeReg matches the register.
REQ-023 When a set and a clear hit the same register on the same edge, set SHALL win and the bit SHALL remain 1.
REQ-024 Register x0 SHALL never be pending.
REQ-025 readBusy[i] SHALL equal pending[readReg[i]], masked to 0 when BYPASS=1 and the same-cycle writeback matches readReg[i].
REQ-026 pendCount SHALL be registered and SHALL equal the population count of the pending bits after each edge, giving 1 cycle of latency.
REQ-027 pendCount SHALL saturate at NREGS-1.
REQ-028 wbErr SHALL set on the edge where RegWrite=1, writeReg!=0 and the target register is not pending.
REQ-029 wbErr SHALL clear only on reset.
REQ-030 Multiple read ports addressing the same register SHALL return identical data and busy values.

Reset
REQ-031 When RESET_N=0, all registers SHALL clear to 0 immediately, including mid-write.
REQ-032 When RESET_N=0, all pending bits, pendCount and wbErr SHALL clear to 0 immediately.
REQ-033 While RESET_N=0, readData SHALL be 0 and readBusy SHALL be 0.
REQ-034 Writes and issues presented during reset SHALL be ignored.
REQ-035 The first write SHALL take effect on the first rising edge after RESET_N deasserts.

Structure
REQ-036 Package banco_pkg SHALL hold defaults XLEN_DEF=32 and NREGS_DEF=32.
REQ-037 Package banco_pkg SHALL hold typedefs reg_addr_t and reg_data_t, and the function popcount.
REQ-038 The pending bits, set/clear priority, pendCount and wbErr logic SHALL live in sub-module marcador_pendientes.
REQ-039 Register storage and read/bypass muxing SHALL stay in banco_registros_mp.

Verification
REQ-040 x0: write 32'h000000A1 to reg 0, then read port 0 at 0 -> readData[0]=0 and wbErr=0, since x0 writes are discarded.
REQ-041 Write: write 32'h0000A234 to reg 13 (RegWrite=1), one edge later read port 0 at 13 -> readData[0]=32'h0000A234.
REQ-042 Dual read: write reg 16=32'h1234 and reg 24=32'h2345 on consecutive edges, then readReg=(16,24) -> readData=(32'h1234,32'h2345) in the same cycle.
REQ-043 Bypass: BYPASS=1, writeReg=5, writeData=32'hDEAD_BEEF, RegWrite=1, and readReg[1]=5 in the same cycle -> readData[1]=32'hDEADBEEF and readBusy[1]=0.
REQ-044 Bypass off: with BYPASS=0 under the same stimulus as REQ-043, the old value is returned in that cycle.
REQ-045 Scoreboard: issue reg 7 -> readBusy=1 and pendCount=1; simultaneous issue 7 plus writeback 7 -> still pending; writeback 7 alone -> pendCount=0.
REQ-046 Error/reset: writeback reg 9 while not pending -> wbErr=1; assert RESET_N=0 mid-cycle -> all outputs 0 asynchronously, and reg 9 reads 0 after release.
